button_reader: RTL and testbench

Debounced push-button input reader for the TinyFPGA B2 design. Where the LED path drives a pin, this block reads one: it synchronises an asynchronous button pin into `clk`, rejects contact bounce, and reports clean level, single-cycle press/release events, an optional long-press event and a wrapping press counter. Downstream logic, such as LED mode selection, consumes these events directly.

---
 rtl/button_reader_if.sv | 41 ++++
 rtl/button_reader.sv | 150 +++++++++++++++
 tb/tb_button_reader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_reader_if.sv
// ---------------------------------------------------------------------------
// button_reader_if
//   Bundles the raw button pin and the debounced event outputs of
//   button_reader so that consumers connect with a single port.
//
//   pin14          raw button pin, asynchronous to the reader's clock
//   btn_level      debounced pressed level, 1 = pressed
//   press_pulse    one-cycle pulse on each accepted press
//   release_pulse  one-cycle pulse on each accepted release
//   long_press     one-cycle pulse when a press has been held long enough
//   press_count    accepted-press counter, wraps modulo 256
//
//   slave  : the reader (consumes pin14, produces the events)
//   master : whoever owns the pin and consumes the events
// ---------------------------------------------------------------------------
interface button_reader_if;
  logic       pin14;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press;
  logic [7:0] press_count;

  modport master (
    output pin14,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_press,
    input  press_count
  );

  modport slave (
    input  pin14,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_press,
    output press_count
  );
endinterface

// File: rtl/button_reader.sv
// ---------------------------------------------------------------------------
// button_reader
//   Synchronises an asynchronous push-button pin, rejects contact bounce and
//   reports a clean level, single-cycle press/release events, an optional
//   long-press event and a wrapping press counter.
//
//   Parameters
//     DEBOUNCE_CYCLES  stable-input cycles needed to accept a change (>= 2)
//     LONG_CYCLES      cycles held pressed before long_press fires
//                      (must exceed DEBOUNCE_CYCLES)
//     ACTIVE_LOW       1: pin reads 0 when pressed, 0: pin reads 1 when pressed
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     btn    button_reader_if.slave: pin14 in; btn_level, press_pulse,
//            release_pulse, long_press, press_count out
//
//   Build option
//     BUTTON_READER_LONG_PRESS_EN  when defined, the hold counter and the
//     long_press event are compiled in; otherwise long_press is tied to 0
//     and LONG_CYCLES has no effect.
// ---------------------------------------------------------------------------
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 160000,
  parameter int LONG_CYCLES     = 16000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  button_reader_if.slave  btn
);

`ifdef BUTTON_READER_LONG_PRESS_EN
  localparam int CNT_W = $clog2(LONG_CYCLES + 1);
`else
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
`endif

  localparam logic [CNT_W-1:0] DC_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  // Pin level when the button is not pressed.
  localparam logic PIN_IDLE = ACTIVE_LOW;

  logic             sync1_reg;
  logic             sync2_reg;
  logic [1:0]       state_reg;
  logic [CNT_W-1:0] dcnt_reg;
  logic             active;

  // Button pressed, as seen after the two-flop synchroniser.
  assign active = sync2_reg ^ ACTIVE_LOW;

  // Synchroniser, debounce FSM and the level/press/release outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg         <= PIN_IDLE;
      sync2_reg         <= PIN_IDLE;
      state_reg         <= RELEASED;
      dcnt_reg          <= '0;
      btn.btn_level     <= 1'b0;
      btn.press_pulse   <= 1'b0;
      btn.release_pulse <= 1'b0;
      btn.press_count   <= 8'd0;
    end else begin
      sync1_reg         <= btn.pin14;
      sync2_reg         <= sync1_reg;
      btn.press_pulse   <= 1'b0;
      btn.release_pulse <= 1'b0;

      case (state_reg)
        RELEASED: begin
          if (active) begin
            state_reg <= PRESS_WAIT;
            dcnt_reg  <= '0;
          end
        end

        PRESS_WAIT: begin
          // Any released sample is treated as bounce: start over.
          if (!active) begin
            state_reg <= RELEASED;
          end else if (dcnt_reg == DC_LAST) begin
            state_reg       <= PRESSED;
            btn.btn_level   <= 1'b1;
            btn.press_pulse <= 1'b1;
            btn.press_count <= btn.press_count + 8'd1;
          end else begin
            dcnt_reg <= dcnt_reg + 1'b1;
          end
        end

        PRESSED: begin
          if (!active) begin
            state_reg <= RELEASE_WAIT;
            dcnt_reg  <= '0;
          end
        end

        RELEASE_WAIT: begin
          // A pressed sample means the release was bounce; no event.
          if (active) begin
            state_reg <= PRESSED;
          end else if (dcnt_reg == DC_LAST) begin
            state_reg         <= RELEASED;
            btn.btn_level     <= 1'b0;
            btn.release_pulse <= 1'b1;
          end else begin
            dcnt_reg <= dcnt_reg + 1'b1;
          end
        end

        default: state_reg <= RELEASED;
      endcase
    end
  end

`ifdef BUTTON_READER_LONG_PRESS_EN
  // hcnt counts cycles spent in PRESSED with the button still active and
  // parks at LONG_CYCLES. The pulse fires on the step into the parked value,
  // which lands exactly LONG_CYCLES edges after press_pulse rises and can
  // only happen once per press. Bounces through RELEASE_WAIT freeze it.
  localparam logic [CNT_W-1:0] HC_SAT = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] hcnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_reg       <= '0;
      btn.long_press <= 1'b0;
    end else begin
      btn.long_press <= 1'b0;
      if (state_reg == PRESS_WAIT && active && dcnt_reg == DC_LAST) begin
        hcnt_reg <= '0;
      end else if (state_reg == PRESSED && active && hcnt_reg != HC_SAT) begin
        hcnt_reg       <= hcnt_reg + 1'b1;
        btn.long_press <= (hcnt_reg == HC_SAT - 1'b1);
      end
    end
  end
`else
  assign btn.long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_reader.sv
// ---------------------------------------------------------------------------
// tb_button_reader
//   Directed and random stimulus for button_reader. A reference model works
//   from the observable rules: the reader sees the pin two edges late, and a
//   level change is accepted once the delayed sample has disagreed with the
//   current level on DEBOUNCE_CYCLES+1 consecutive edges. A separate process
//   compares every DUT output against the model on each falling edge; the
//   directed sections add hand-computed cycle-exact expectations.
// ---------------------------------------------------------------------------
module tb_button_reader;
  localparam int D  = 4;
  localparam int L  = 20;
  localparam bit AL = 1'b1;
`ifdef BUTTON_READER_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_reader_if bus ();

  button_reader #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .ACTIVE_LOW      (AL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit       m_level = 1'b0;
  bit       m_press = 1'b0;
  bit       m_rel   = 1'b0;
  bit       m_long  = 1'b0;
  bit [7:0] m_count = 8'd0;
  int       run     = 0;   // consecutive edges disagreeing with m_level
  int       held    = 0;   // edges counted toward long_press
  bit       hist[$];       // pin values seen at the last two edges

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, required %0d", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    hist    = {AL, AL};
    m_level = 1'b0;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    m_count = 8'd0;
    run     = 0;
    held    = 0;
  endtask

  // Model update at every rising edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        bit act;
        act = (hist[0] != AL);
        void'(hist.pop_front());
        hist.push_back(bus.pin14);
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (act != m_level) begin
          run++;
          if (run == D + 1) begin
            m_level = act;
            run     = 0;
            if (act) begin
              m_press = 1'b1;
              m_count = m_count + 8'd1;
              held    = 0;
            end else begin
              m_rel = 1'b1;
            end
          end
        end else begin
          // Only an uninterrupted pressed edge advances the hold count.
          if (m_level && run == 0 && LP_EN && held < L) begin
            held++;
            if (held == L) m_long = 1'b1;
          end
          run = 0;
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("cmp_level_rst",   {7'd0, bus.btn_level},     8'd0);
        check("cmp_press_rst",   {7'd0, bus.press_pulse},   8'd0);
        check("cmp_release_rst", {7'd0, bus.release_pulse}, 8'd0);
        check("cmp_long_rst",    {7'd0, bus.long_press},    8'd0);
        check("cmp_count_rst",   bus.press_count,           8'd0);
      end else begin
        check("cmp_level",   {7'd0, bus.btn_level},     {7'd0, m_level});
        check("cmp_press",   {7'd0, bus.press_pulse},   {7'd0, m_press});
        check("cmp_release", {7'd0, bus.release_pulse}, {7'd0, m_rel});
        check("cmp_long",    {7'd0, bus.long_press},    {7'd0, m_long});
        check("cmp_count",   bus.press_count,           m_count);
        check("cmp_excl",    {7'd0, bus.press_pulse & bus.release_pulse}, 8'd0);
      end
    end
  end

  // Drive the pin right after a falling edge and let n falling edges pass.
  task automatic hold(input bit v, input int n);
    bus.pin14 = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pin14 = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle: pin high for 50 cycles.
    hold(1'b1, 50);
    check("idle_level", {7'd0, bus.btn_level}, 8'd0);
    check("idle_count", bus.press_count, 8'd0);

    // Clean press held 30 cycles; e0 is the next rising edge.
    bus.pin14 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check($sformatf("press_pulse_e%0d", k), {7'd0, bus.press_pulse}, {7'd0, (k == 6)});
      check($sformatf("press_level_e%0d", k), {7'd0, bus.btn_level},   {7'd0, (k >= 6)});
      check($sformatf("long_e%0d", k),        {7'd0, bus.long_press},  {7'd0, (LP_EN && k == 26)});
    end
    check("press_count_1", bus.press_count, 8'd1);

    // Release with a one-cycle bounce: 1,1,0 then 1 held (f0 = next edge).
    hold(1'b1, 2);
    hold(1'b0, 1);
    bus.pin14 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("rel_pulse_f%0d", k), {7'd0, bus.release_pulse}, {7'd0, (k == 6)});
      check($sformatf("rel_nopress_f%0d", k), {7'd0, bus.press_pulse}, 8'd0);
    end
    check("rel_count", bus.press_count, 8'd1);
    check("rel_level", {7'd0, bus.btn_level}, 8'd0);

    // Short bounce: 3 cycles low is not a press.
    hold(1'b0, 3);
    hold(1'b1, 12);
    check("bounce_count", bus.press_count, 8'd1);
    check("bounce_level", {7'd0, bus.btn_level}, 8'd0);

    // Counter wrap: 257 clean presses from reset.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 257; i++) begin
      hold(1'b0, 10);
      check($sformatf("wrap_count_%0d", i), bus.press_count, 8'(i % 256));
      hold(1'b1, 10);
    end

    // Random pin activity, occasionally held long enough for long_press.
    for (int i = 0; i < 1500; i++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(1, 7));
      hold(1'($urandom_range(0, 1)), len);
    end

    // Reset while pressed with the pin still held.
    hold(1'b1, 12);
    hold(1'b0, 12);
    check("midrst_pre_level", {7'd0, bus.btn_level}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_level",   {7'd0, bus.btn_level},     8'd0);
    check("midrst_press",   {7'd0, bus.press_pulse},   8'd0);
    check("midrst_release", {7'd0, bus.release_pulse}, 8'd0);
    check("midrst_long",    {7'd0, bus.long_press},    8'd0);
    check("midrst_count",   bus.press_count,           8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("repress_pulse_e%0d", k), {7'd0, bus.press_pulse}, {7'd0, (k == 6)});
    end
    check("repress_count", bus.press_count, 8'd1);
    hold(1'b1, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
